rr_arbiter8: RTL

Round-robin arbiter that shares one 3-to-8 decoder select among eight requesters. It picks one active request each arbitration cycle and drives the 3-bit select index into a `decoder3to8` instance, which produces a one-hot grant. A per-grant hold counter caps how long any requester can keep the grant. The block sits between requesting agents and the shared decoded resource.

---
 rtl/rr_arbiter8_pkg.sv | 17 +
 rtl/rr_arbiter8_decoder.sv | 14 +
 rtl/rr_arbiter8.sv | 98 +++++++++
 3 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter and its decoder.
package rr_arbiter8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

endpackage

// File: rtl/rr_arbiter8_decoder.sv
// Existing 3-to-8 binary decoder: Y is one-hot on I.
module decoder3to8
  import rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0] I,
  output logic [N_REQ-1:0] Y
);

  always_comb begin
    Y = '0;
    Y[I] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with a per-grant hold limit;
// the granted index drives a shared 3-to-8 decoder.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   hold_cnt;
  pick_t              win;
  logic [N_REQ-1:0]   dec_y;

  // First set bit at or after p, wrapping; the holder sits at ptr-1 so it is found last.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] p);
    pick_t            res;
    logic [IDX_W-1:0] k;
    res = '0;
    for (int unsigned n = 0; n < N_REQ; n++) begin
      k = p + IDX_W'(n);
      if (!res.found && r[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

  always_comb win = rr_pick(req, ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win.found) begin
            state       <= GRANT;
            grant_idx   <= win.idx;
            grant_valid <= 1'b1;
            ptr         <= win.idx + IDX_W'(1);
            hold_cnt    <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (!req[grant_idx]) begin
            if (win.found) begin
              grant_idx <= win.idx;
              ptr       <= win.idx + IDX_W'(1);
              hold_cnt  <= CNT_W'(1);
            end else begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              hold_cnt    <= '0;
            end
          end else if (hold_cnt == CNT_W'(HOLD_MAX)) begin
            // Holder still requests, so win.found is guaranteed; a sole holder is regranted.
            timeout   <= 1'b1;
            grant_idx <= win.idx;
            ptr       <= win.idx + IDX_W'(1);
            hold_cnt  <= CNT_W'(1);
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  decoder3to8 u_dec (
    .I (grant_idx),
    .Y (dec_y)
  );

  assign grant_onehot = grant_valid ? dec_y : '0;

endmodule
